// File: rtl/uart_rx_cfg_if.sv
// rtl/uart_rx_cfg_if.sv - receive-side word/strobe bundle of the configurable UART receiver
//
// Purpose: carries the received word and its status strobes from the
// receiver to the byte-stream consumer.
// Signals:
//   dat        [DATA_BITS] received word, LSB-first on the line
//   dat_en     one-cycle strobe, dat valid in this cycle
//   parity_err one-cycle strobe, coincident with dat_en, on parity mismatch
//   frame_err  one-cycle strobe when a stop bit samples 0
//   busy       high whenever the receiver is not idle
// Modports: master = receiver (drives), slave = consumer (observes).
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] dat;
  logic                 dat_en;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (output dat, output dat_en, output parity_err, output frame_err, output busy);
  modport slave  (input  dat, input  dat_en, input  parity_err, input  frame_err, input  busy);
endinterface

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised UART receiver with parity/framing checks and break recovery
//
// Purpose: deserialises the asynchronous rx line into DATA_BITS-wide words.
// Parameters: CLKS_PER_BIT (8..65535), DATA_BITS (5..9),
//             PARITY (0 none, 1 odd, 2 even), STOP_BITS (1 or 2).
// Optional build macro: UART_RX_MAJORITY_EN - each sample point takes a
//   2-of-3 vote of rxs at cnt = 2, 1, 0 instead of a single sample at cnt = 0.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   rx     serial line, asynchronous, idle high
//   rx_if  uart_rx_cfg_if.master: dat, dat_en, parity_err, frame_err, busy
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx,
  uart_rx_cfg_if.master  rx_if
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bad;
  logic                 stop_n;
  logic                 rx_meta;
  logic                 rxs;
  logic                 samp;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Samples captured one and two cycles before the decision point.
  logic s2;
  logic s1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2 <= 1'b1;
      s1 <= 1'b1;
    end else begin
      if (cnt == CW'(2)) s2 <= rxs;
      if (cnt == CW'(1)) s1 <= rxs;
    end
  end

  assign samp = (s2 & s1) | (s2 & rxs) | (s1 & rxs);
`else
  assign samp = rxs;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      idx              <= '0;
      shift            <= '0;
      par_bad          <= 1'b0;
      stop_n           <= 1'b0;
      rx_if.dat        <= '0;
      rx_if.dat_en     <= 1'b0;
      rx_if.parity_err <= 1'b0;
      rx_if.frame_err  <= 1'b0;
      rx_if.busy       <= 1'b0;
    end else begin
      rx_if.dat_en     <= 1'b0;
      rx_if.parity_err <= 1'b0;
      rx_if.frame_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (!rxs) begin
            state      <= START;
            cnt        <= CNT_HALF;
            rx_if.busy <= 1'b1;
          end
        end

        START: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!samp) begin
            state   <= DATA;
            cnt     <= CNT_FULL;
            idx     <= '0;
            par_bad <= 1'b0;
            stop_n  <= 1'b0;
          end else begin
            // Start bit did not hold until mid-bit: glitch.
            state      <= IDLE;
            rx_if.busy <= 1'b0;
          end
        end

        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            shift <= {samp, shift[DATA_BITS-1:1]};
            idx   <= idx + IW'(1);
            cnt   <= CNT_FULL;
            if (idx == IDX_LAST) state <= (PARITY != 0) ? PAR : STOP;
          end
        end

        PAR: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            // Odd parity wants data^p == 1, even wants 0.
            par_bad <= (PARITY == 1) ? ~(^shift ^ samp) : (^shift ^ samp);
            state   <= STOP;
            cnt     <= CNT_FULL;
          end
        end

        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!samp) begin
            rx_if.frame_err <= 1'b1;
            state           <= BRK;
          end else if (stop_n == STOP_LAST) begin
            rx_if.dat        <= shift;
            rx_if.dat_en     <= 1'b1;
            rx_if.parity_err <= par_bad;
            state            <= IDLE;
            rx_if.busy       <= 1'b0;
          end else begin
            stop_n <= 1'b1;
            cnt    <= CNT_FULL;
          end
        end

        BRK: begin
          // Hold off start detection until the line returns high.
          if (rxs) begin
            state      <= IDLE;
            rx_if.busy <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          rx_if.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed self-checking bench for uart_rx_cfg
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] rx_line = 3'b111;

  always #5 clk = ~clk;

  uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if2 ();

  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .rx(rx_line[0]), .rx_if(if0.master));
  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .rx(rx_line[1]), .rx_if(if1.master));
  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .rx(rx_line[2]), .rx_if(if2.master));

  int     checks = 0;
  int     errors = 0;
  int     en_n[3];
  int     ferr_n[3];
  int     last_dat[3];
  int     last_perr[3];
  int     overlap_n = 0;
  int     log2[$];
  longint t_en0 = 0;
  longint t_fall[3];
  bit     busy_seen0 = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (if0.dat_en) begin
      en_n[0]++; last_dat[0] = int'(if0.dat); last_perr[0] = int'(if0.parity_err); t_en0 = $time;
    end
    if (if0.frame_err) ferr_n[0]++;
    if (if0.busy) busy_seen0 = 1'b1;
    if (if1.dat_en) begin
      en_n[1]++; last_dat[1] = int'(if1.dat); last_perr[1] = int'(if1.parity_err);
    end
    if (if1.frame_err) ferr_n[1]++;
    if (if2.dat_en) begin
      en_n[2]++; last_dat[2] = int'(if2.dat); log2.push_back(int'(if2.dat));
    end
    if (if2.frame_err) ferr_n[2]++;
    if ((if0.dat_en && if0.frame_err) || (if1.dat_en && if1.frame_err) ||
        (if2.dat_en && if2.frame_err)) overlap_n++;
  end

  // Sends n bits LSB first, 16 clocks each; gb selects a bit to receive a
  // one-clock inverted glitch at its middle (-1 for none).
  task automatic send_bits(input int k, input logic [15:0] bits, input int n, input int gb);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 16; j++) begin
        @(posedge clk); #1;
        if (i == 0 && j == 0) t_fall[k] = $time;
        rx_line[k] = (i == gb && j == 8) ? ~bits[i] : bits[i];
      end
    end
  endtask

  task automatic hold(input int k, input logic v, input int nclk);
    for (int i = 0; i < nclk; i++) begin
      @(posedge clk); #1;
      rx_line[k] = v;
    end
  endtask

  initial begin
    longint lat;
    for (int i = 0; i < 3; i++) begin
      en_n[i] = 0; ferr_n[i] = 0; last_dat[i] = 0; last_perr[i] = 0; t_fall[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_dat", int'(if0.dat), 0);
    check("rst_dat_en", int'(if0.dat_en), 0);
    check("rst_busy", int'(if0.busy), 0);
    hold(0, 1'b1, 4);

    // 8N1 0xA5 and latency
    send_bits(0, 16'({1'b1, 8'hA5, 1'b0}), 10, -1);
    hold(0, 1'b1, 32);
    check("a5_count", en_n[0], 1);
    check("a5_dat", last_dat[0], 32'hA5);
    check("a5_perr", last_perr[0], 0);
    check("a5_ferr", ferr_n[0], 0);
    lat = (t_en0 - t_fall[0]) / 10;
    check("a5_latency_in_153_155", int'(lat >= 153 && lat <= 155), 1);

    // Start-bit glitch: 5 clocks low
    busy_seen0 = 1'b0;
    hold(0, 1'b0, 5);
    hold(0, 1'b1, 10);
    @(negedge clk);
    check("glitch_busy_seen", int'(busy_seen0), 1);
    check("glitch_busy_end", int'(if0.busy), 0);
    check("glitch_no_en", en_n[0], 1);
    check("glitch_no_ferr", ferr_n[0], 0);

    // Even parity: 0x03 with p=1 is wrong, with p=0 is right
    send_bits(1, 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11, -1);
    hold(1, 1'b1, 32);
    check("par1_count", en_n[1], 1);
    check("par1_dat", last_dat[1], 3);
    check("par1_perr", last_perr[1], 1);
    send_bits(1, 16'({1'b1, 1'b0, 8'h03, 1'b0}), 11, -1);
    hold(1, 1'b1, 32);
    check("par0_count", en_n[1], 2);
    check("par0_perr", last_perr[1], 0);

    // Framing error then held-low break, then recovery
    send_bits(0, 16'({1'b0, 8'h5A, 1'b0}), 10, -1);
    hold(0, 1'b0, 200);
    check("brk_ferr", ferr_n[0], 1);
    check("brk_no_en", en_n[0], 1);
    check("brk_dat_hold", last_dat[0], 32'hA5);
    hold(0, 1'b1, 32);
    send_bits(0, 16'({1'b1, 8'h3C, 1'b0}), 10, -1);
    hold(0, 1'b1, 32);
    check("brk_rec_count", en_n[0], 2);
    check("brk_rec_dat", last_dat[0], 32'h3C);
    check("brk_ferr_once", ferr_n[0], 1);

    // 7 data bits, 2 stop bits, back-to-back
    send_bits(2, 16'({2'b11, 7'h41, 1'b0}), 10, -1);
    send_bits(2, 16'({2'b11, 7'h7F, 1'b0}), 10, -1);
    send_bits(2, 16'({2'b11, 7'h00, 1'b0}), 10, -1);
    hold(2, 1'b1, 32);
    check("b2b_count", en_n[2], 3);
    check("b2b_0", (log2.size() > 0) ? log2[0] : -1, 32'h41);
    check("b2b_1", (log2.size() > 1) ? log2[1] : -1, 32'h7F);
    check("b2b_2", (log2.size() > 2) ? log2[2] : -1, 32'h00);
    send_bits(2, 16'({1'b0, 1'b1, 7'h55, 1'b0}), 10, -1);
    hold(2, 1'b1, 32);
    check("stop2_ferr", ferr_n[2], 1);
    check("stop2_no_en", en_n[2], 3);

    // Reset in the middle of 0xFF's data bits
    send_bits(0, 16'b1110, 4, -1);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_dat", int'(if0.dat), 0);
    check("mid_rst_busy", int'(if0.busy), 0);
    check("mid_rst_en", int'(if0.dat_en), 0);
    hold(0, 1'b1, 160);
    check("mid_rst_no_en", en_n[0], 2);
    check("mid_rst_no_ferr", ferr_n[0], 1);
    send_bits(0, 16'({1'b1, 8'h11, 1'b0}), 10, -1);
    hold(0, 1'b1, 32);
    check("post_rst_count", en_n[0], 3);
    check("post_rst_dat", last_dat[0], 32'h11);

`ifdef UART_RX_MAJORITY_EN
    // One-clock high spike at mid-bit of data bit 0 is voted out
    send_bits(0, 16'({1'b1, 8'h00, 1'b0}), 10, 1);
    hold(0, 1'b1, 32);
    check("maj_count", en_n[0], 4);
    check("maj_dat", last_dat[0], 0);
`endif

    check("no_overlap", overlap_n, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
